// File: rtl/peak_sequencer.sv
// Per-channel peak search over a lag-indexed correlation memory.
// Reads each channel's NUM_LAGS samples in order and reports the peak lag and value.
module peak_sequencer #(
  parameter int MAX_LAGS     = 17,
  parameter int NUM_CHANNELS = 3,
  parameter int DATA_WIDTH   = 32,
  parameter int ABS_MODE     = 0,
  localparam int NUM_LAGS    = 2*MAX_LAGS+1,
  localparam int LW          = $clog2(NUM_LAGS),
  localparam int CW          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int PLW         = $clog2(MAX_LAGS+1)+1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  output logic                         rdEn,
  output logic [LW-1:0]                rdLag,
  output logic [CW-1:0]                rdChannel,
  input  logic signed [DATA_WIDTH-1:0] corrData,
  output logic                         busy,
  output logic                         peakValid,
  output logic [CW-1:0]                peakChannel,
  output logic signed [PLW-1:0]        peakLag,
  output logic [DATA_WIDTH-1:0]        peakValue,
  output logic                         done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DRAIN, REPORT, DONE
  } state_t;

  localparam logic [LW-1:0] LAST_LAG = LW'(NUM_LAGS-1);
  localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CHANNELS-1);
  localparam logic signed [DATA_WIDTH-1:0] SMIN =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] SMAX =
    {1'b0, {(DATA_WIDTH-1){1'b1}}};

  state_t nxt;
  state_t state;

  logic [LW-1:0] lag;
  logic [LW-1:0] lag_q;
  logic [CW-1:0] chan;
  logic          rd_q;

  logic signed [DATA_WIDTH-1:0] max_v;
  logic signed [DATA_WIDTH-1:0] cand;
  logic signed [DATA_WIDTH-1:0] new_v;
  logic [LW-1:0]                max_i;
  logic [LW-1:0]                new_i;
  logic                         take;
  logic signed [LW:0]           off;

  logic [CW-1:0]                pk_ch;
  logic signed [PLW-1:0]        pk_lag;
  logic [DATA_WIDTH-1:0]        pk_val;

  // Sample arriving now belongs to the lag read on the previous cycle
  always_comb begin
    cand = corrData;
    if (ABS_MODE != 0 && corrData[DATA_WIDTH-1])
      cand = (corrData == SMIN) ? SMAX : -corrData;
    take  = rd_q && ((lag_q == '0) || (cand > max_v));
    new_v = take ? cand  : max_v;
    new_i = take ? lag_q : max_i;
    off   = $signed({1'b0, new_i}) - $signed((LW+1)'(MAX_LAGS));
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = FETCH;
      FETCH:   if (lag == LAST_LAG) nxt = DRAIN;
      DRAIN:   nxt = REPORT;
      REPORT:  nxt = (chan == LAST_CH) ? DONE : FETCH;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort && state != IDLE) nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lag    <= '0;
      lag_q  <= '0;
      chan   <= '0;
      rd_q   <= 1'b0;
      max_v  <= '0;
      max_i  <= '0;
      pk_ch  <= '0;
      pk_lag <= '0;
      pk_val <= '0;
    end else begin
      state <= nxt;
      rd_q  <= (state == FETCH);
      lag_q <= lag;
      max_v <= new_v;
      max_i <= new_i;
      if (state == FETCH && nxt == FETCH)
        lag <= lag + 1'b1;
      else
        lag <= '0;
      if (nxt == IDLE)
        chan <= '0;
      else if (state == REPORT && nxt == FETCH)
        chan <= chan + 1'b1;
      // DRAIN sees the final sample, so latch the result here
      if (state == DRAIN && nxt == REPORT) begin
        pk_ch  <= chan;
        pk_lag <= PLW'(off);
        pk_val <= new_v;
      end
    end
  end

  assign busy        = ~rst & (state != IDLE);
  assign rdEn        = ~rst & (state == FETCH);
  assign peakValid   = ~rst & (state == REPORT);
  assign done        = ~rst & (state == DONE);
  assign rdLag       = rst ? '0 : lag;
  assign rdChannel   = rst ? '0 : chan;
  assign peakChannel = rst ? '0 : pk_ch;
  assign peakLag     = rst ? '0 : pk_lag;
  assign peakValue   = rst ? '0 : pk_val;

endmodule

// File: tb/tb_peak_sequencer.sv
// Directed bench for peak_sequencer: default, magnitude-mode and
// minimal-size instances driven from small memory models.
module tb_peak_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Instance A: defaults
  logic a_rst = 1'b1, a_start = 1'b0, a_abort = 1'b0;
  logic a_rdEn, a_busy, a_peakValid, a_done;
  logic [5:0] a_rdLag;
  logic [1:0] a_rdChannel, a_peakChannel;
  logic signed [5:0] a_peakLag;
  logic [31:0] a_peakValue;
  logic signed [31:0] a_corr = '0;
  logic signed [31:0] mem_a [3][35];

  peak_sequencer u_a (
    .clk(clk), .rst(a_rst), .start(a_start), .abort(a_abort),
    .rdEn(a_rdEn), .rdLag(a_rdLag), .rdChannel(a_rdChannel),
    .corrData(a_corr), .busy(a_busy), .peakValid(a_peakValid),
    .peakChannel(a_peakChannel), .peakLag(a_peakLag),
    .peakValue(a_peakValue), .done(a_done)
  );

  always @(posedge clk)
    if (a_rdEn) a_corr <= mem_a[a_rdChannel][a_rdLag];

  // Instance B: magnitude mode, 8-bit, one channel
  logic bc_rst = 1'b1, b_start = 1'b0, c_start = 1'b0;
  logic b_rdEn, b_busy, b_peakValid, b_done;
  logic [5:0] b_rdLag;
  logic [0:0] b_rdChannel, b_peakChannel;
  logic signed [5:0] b_peakLag;
  logic [7:0] b_peakValue;
  logic signed [7:0] b_corr = '0;
  logic signed [7:0] mem_b [35];

  peak_sequencer #(.NUM_CHANNELS(1), .DATA_WIDTH(8), .ABS_MODE(1)) u_b (
    .clk(clk), .rst(bc_rst), .start(b_start), .abort(1'b0),
    .rdEn(b_rdEn), .rdLag(b_rdLag), .rdChannel(b_rdChannel),
    .corrData(b_corr), .busy(b_busy), .peakValid(b_peakValid),
    .peakChannel(b_peakChannel), .peakLag(b_peakLag),
    .peakValue(b_peakValue), .done(b_done)
  );

  always @(posedge clk)
    if (b_rdEn) b_corr <= mem_b[b_rdLag];

  // Instance C: three lags, one channel, constant -7 memory
  logic c_rdEn, c_busy, c_peakValid, c_done;
  logic [1:0] c_rdLag;
  logic [0:0] c_rdChannel, c_peakChannel;
  logic signed [1:0] c_peakLag;
  logic [31:0] c_peakValue;
  logic signed [31:0] c_corr = '0;

  peak_sequencer #(.MAX_LAGS(1), .NUM_CHANNELS(1)) u_c (
    .clk(clk), .rst(bc_rst), .start(c_start), .abort(1'b0),
    .rdEn(c_rdEn), .rdLag(c_rdLag), .rdChannel(c_rdChannel),
    .corrData(c_corr), .busy(c_busy), .peakValid(c_peakValid),
    .peakChannel(c_peakChannel), .peakLag(c_peakLag),
    .peakValue(c_peakValue), .done(c_done)
  );

  always @(posedge clk)
    if (c_rdEn) c_corr <= -32'sd7;

  // Per-cycle history of instance A
  int pv_h[256], ch_h[256], lag_h[256], val_h[256];
  int done_h[256], busy_h[256], rdlag_h[256], rden_h[256];
  int rdch_h[256], zero_h[256];

  function automatic int a_zero();
    return int'(!a_busy && !a_rdEn && !a_peakValid && !a_done &&
      a_rdLag == 0 && a_rdChannel == 0 && a_peakChannel == 0 &&
      a_peakLag == 0 && a_peakValue == 0);
  endfunction

  task automatic fill_a(input int s);
    for (int c = 0; c < 3; c++)
      for (int l = 0; l < 35; l++) begin
        if (s == 1) begin
          if (c == 0)      mem_a[c][l] = (l == 3 || l == 30) ? 500 : -5;
          else if (c == 1) mem_a[c][l] = (l == 34) ? -3 : -20;
          else             mem_a[c][l] = 7;
        end else if (s == 2) begin
          if (c == 0)      mem_a[c][l] = (l == 10) ? 2000 : 0;
          else if (c == 1) mem_a[c][l] = (l == 20) ? -50 : -100;
          else             mem_a[c][l] = -1;
        end else begin
          mem_a[c][l] = (l == 5 + c) ? 1000 : -(l * 3);
        end
      end
  endtask

  task automatic run_a(input int ab_c, input int st2_c, input int rst_c,
                       input int sb_c, input int ncyc);
    for (int i = 0; i < 256; i++) begin
      pv_h[i] = 0; ch_h[i] = 0; lag_h[i] = 0; val_h[i] = 0;
      done_h[i] = 0; busy_h[i] = 0; rdlag_h[i] = 0; rden_h[i] = 0;
      rdch_h[i] = 0; zero_h[i] = 0;
    end
    @(posedge clk); #1;
    a_start = 1'b1;
    for (int cyc = 1; cyc < ncyc; cyc++) begin
      @(posedge clk); #1;
      pv_h[cyc]    = int'(a_peakValid);
      ch_h[cyc]    = int'(a_peakChannel);
      lag_h[cyc]   = int'(a_peakLag);
      val_h[cyc]   = int'(a_peakValue);
      done_h[cyc]  = int'(a_done);
      busy_h[cyc]  = int'(a_busy);
      rdlag_h[cyc] = int'(a_rdLag);
      rden_h[cyc]  = int'(a_rdEn);
      rdch_h[cyc]  = int'(a_rdChannel);
      zero_h[cyc]  = a_zero();
      a_start = (cyc == st2_c) || (cyc == sb_c);
      a_abort = (cyc == ab_c);
      a_rst   = (cyc == rst_c);
    end
    a_start = 1'b0;
    a_abort = 1'b0;
    a_rst   = 1'b0;
  endtask

  typedef struct {
    int scen; int cyc; int ch; int lag; int val;
  } vec_t;

  typedef struct {
    int i0; int v0; int i1; int v1; int lag; int val;
  } bvec_t;

  vec_t  vt [21];
  bvec_t bt [3];
  int ab_p[5], st2_p[5], rst_p[5], sb_p[5], ncyc_p[5], npv_p[5];

  initial begin
    int npv, ndone, got_c, got_l, got_v, got_d;

    vt = '{
      '{0, 37, 0, -12, 1000}, '{0, 74, 1, -11, 1000},
      '{0, 111, 2, -10, 1000}, '{0, 112, -1, 0, 0},
      '{1, 37, 0, -14, 500}, '{1, 74, 1, 17, -3},
      '{1, 111, 2, -17, 7}, '{1, 112, -1, 0, 0},
      '{2, 37, 0, -7, 2000}, '{2, 74, 1, 3, -50},
      '{2, 111, 2, -17, -1}, '{2, 112, -1, 0, 0},
      '{3, 37, 0, -12, 1000}, '{3, 89, 0, -12, 1000},
      '{3, 126, 1, -11, 1000}, '{3, 163, 2, -10, 1000},
      '{3, 164, -1, 0, 0},
      '{4, 58, 0, -12, 1000}, '{4, 95, 1, -11, 1000},
      '{4, 132, 2, -10, 1000}, '{4, 133, -1, 0, 0}
    };
    ab_p   = '{-1, -1, -1, 50, -1};
    st2_p  = '{-1, -1, -1, 52, 21};
    rst_p  = '{-1, -1, -1, -1, 20};
    sb_p   = '{-1, -1, -1, -1, 10};
    ncyc_p = '{120, 120, 120, 180, 150};
    npv_p  = '{3, 3, 3, 4, 3};
    bt = '{
      '{0, -128, 34, 100, -17, 127},
      '{3, -5, 4, 5, -14, 5},
      '{20, -100, 5, 99, 3, 100}
    };

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_a_zero", a_zero(), 1);
    end
    chk("reset_b_busy", int'(b_busy), 0);
    chk("reset_c_busy", int'(c_busy), 0);
    a_rst = 1'b0;
    bc_rst = 1'b0;

    for (int s = 0; s < 5; s++) begin
      fill_a(s);
      run_a(ab_p[s], st2_p[s], rst_p[s], sb_p[s], ncyc_p[s]);
      for (int v = 0; v < 21; v++) begin
        if (vt[v].scen == s) begin
          if (vt[v].ch < 0) begin
            chk($sformatf("s%0d_done@%0d", s, vt[v].cyc), done_h[vt[v].cyc], 1);
          end else begin
            chk($sformatf("s%0d_pv@%0d", s, vt[v].cyc), pv_h[vt[v].cyc], 1);
            chk($sformatf("s%0d_ch@%0d", s, vt[v].cyc), ch_h[vt[v].cyc], vt[v].ch);
            chk($sformatf("s%0d_lag@%0d", s, vt[v].cyc), lag_h[vt[v].cyc], vt[v].lag);
            chk($sformatf("s%0d_val@%0d", s, vt[v].cyc), val_h[vt[v].cyc], vt[v].val);
          end
        end
      end
      npv = 0;
      ndone = 0;
      for (int c = 0; c < 256; c++) begin
        npv += pv_h[c];
        ndone += done_h[c];
      end
      chk($sformatf("s%0d_pv_count", s), npv, npv_p[s]);
      chk($sformatf("s%0d_done_count", s), ndone, 1);
      if (s == 0) begin
        chk("s0_busy_c1", busy_h[1], 1);
        chk("s0_rdlag_last", rdlag_h[35], 34);
        chk("s0_rden_drain", rden_h[36], 0);
        chk("s0_rdch_c40", rdch_h[40], 1);
        chk("s0_pv_drain", pv_h[36], 0);
        chk("s0_pv_after", pv_h[38], 0);
        chk("s0_hold_lag", lag_h[112], -10);
        chk("s0_hold_val", val_h[112], 1000);
        chk("s0_idle_after", busy_h[113], 0);
      end
      if (s == 3) begin
        chk("s3_busy_c50", busy_h[50], 1);
        chk("s3_busy_c51", busy_h[51], 0);
      end
      if (s == 4) begin
        chk("s4_rdlag_c11", rdlag_h[11], 10);
        chk("s4_rdlag_c20", rdlag_h[20], 19);
        chk("s4_zero_c21", zero_h[21], 1);
        chk("s4_busy_c22", busy_h[22], 1);
        chk("s4_lag_clr", lag_h[22], 0);
        chk("s4_val_clr", val_h[22], 0);
      end
    end

    for (int t = 0; t < 3; t++) begin
      for (int l = 0; l < 35; l++) mem_b[l] = 8'sd0;
      mem_b[bt[t].i0] = 8'(bt[t].v0);
      mem_b[bt[t].i1] = 8'(bt[t].v1);
      got_c = -1; got_l = 0; got_v = 0;
      @(posedge clk); #1;
      b_start = 1'b1;
      for (int cyc = 1; cyc < 42; cyc++) begin
        @(posedge clk); #1;
        b_start = 1'b0;
        if (b_peakValid) begin
          got_c = cyc;
          got_l = int'(b_peakLag);
          got_v = int'(b_peakValue);
        end
      end
      chk($sformatf("b%0d_cyc", t), got_c, 37);
      chk($sformatf("b%0d_lag", t), got_l, bt[t].lag);
      chk($sformatf("b%0d_val", t), got_v, bt[t].val);
    end

    got_c = -1; got_l = 0; got_v = 0; got_d = -1;
    @(posedge clk); #1;
    c_start = 1'b1;
    for (int cyc = 1; cyc < 12; cyc++) begin
      @(posedge clk); #1;
      c_start = 1'b0;
      if (c_peakValid) begin
        got_c = cyc;
        got_l = int'(c_peakLag);
        got_v = int'(c_peakValue);
      end
      if (c_done) got_d = cyc;
    end
    chk("c_pv_cyc", got_c, 5);
    chk("c_lag", got_l, -1);
    chk("c_val", got_v, -7);
    chk("c_done_cyc", got_d, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
